// File: rtl/layernorm_stream.sv
// Streaming fixed-point LayerNorm / RMSNorm: buffers one token vector, derives 1/std with
// a bit-serial integer square root and restoring divider, then streams out gamma*n+beta.
module layernorm_stream #(
  parameter int DIM     = 64,
  parameter int LANES   = 1,
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 8,
  parameter int RECIP_W = 16,
  parameter int EPS_RAW = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode_rms,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_W-1:0]   out_data,
  output logic                      out_last,
  input  logic                      cfg_we,
  input  logic [$clog2(2*DIM)-1:0]  cfg_addr,
  input  logic [DATA_W-1:0]         cfg_wdata
);
  localparam int LG  = $clog2(DIM);
  localparam int NB  = DIM / LANES;
  localparam int BCW = $clog2(NB) + 1;
  localparam int SW  = DATA_W + LG;
  localparam int QW  = 2*DATA_W + LG;
  localparam int RW  = 2*DATA_W;
  localparam int RW2 = RW + 2;
  localparam int QTW = FRAC_W + RECIP_W + 1;
  localparam int CW  = $clog2(QTW + DATA_W) + 1;
  localparam int PW  = DATA_W + QTW + 2;
  localparam int YW  = PW + DATA_W;
  localparam logic signed [YW-1:0] YMAX = {{(YW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [YW-1:0] YMIN = {{(YW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {LOAD, STATS, SQRT, DIV, OUT} state_t;

  function automatic logic [LG-1:0] eidx(input logic [BCW-1:0] beat, input int lane);
    int t;
    t = int'(beat) * LANES + lane;
    return LG'(t);
  endfunction

  function automatic logic [RW-1:0] sat_rad(input logic [RW2-1:0] v);
    return (|v[RW2-1:RW]) ? '1 : v[RW-1:0];
  endfunction

  function automatic logic signed [DATA_W-1:0] sat_y(input logic signed [YW-1:0] v);
    if (v > YMAX) return signed'(YMAX[DATA_W-1:0]);
    if (v < YMIN) return signed'(YMIN[DATA_W-1:0]);
    return signed'(v[DATA_W-1:0]);
  endfunction

  state_t                     state_q;
  logic [BCW-1:0]             bcnt_q, ocnt_q;
  logic signed [SW-1:0]       sum_q, sum_d;
  logic [QW-1:0]              sumsq_q, sumsq_d;
  logic                       mode_q;
  logic signed [DATA_W-1:0]   mean_q;
  logic [RW-1:0]              rad_q;
  logic [DATA_W-1:0]          root_q, srem_q, drem_q;
  logic [QTW-1:0]             inv_q;
  logic [CW-1:0]              cnt_q;
  logic signed [DATA_W-1:0]   buf_q   [DIM];
  logic signed [DATA_W-1:0]   gamma_q [DIM];
  logic signed [DATA_W-1:0]   beta_q  [DIM];
  logic                       out_valid_q, out_last_q;
  logic [LANES*DATA_W-1:0]    out_data_q, out_data_d;

  logic signed [DATA_W-1:0]   xl;
  logic signed [RW-1:0]       sq;
  logic signed [DATA_W-1:0]   mean_c;
  logic [RW-1:0]              msq_c;
  logic signed [RW-1:0]       mm_c;
  logic signed [RW2-1:0]      var_c;
  logic [RW2-1:0]             rad_c;
  logic [DATA_W+1:0]          st_c, trial_c;
  logic [DATA_W-1:0]          s_c;
  logic [DATA_W:0]            dr_c;
  logic [LG-1:0]              idx;
  logic signed [DATA_W-1:0]   xo;
  logic signed [PW-1:0]       prod, nn;
  logic signed [YW-1:0]       yw;

  // Load-side accumulation of sum and sum of squares for the beat on in_data
  always_comb begin
    sum_d   = sum_q;
    sumsq_d = sumsq_q;
    xl      = '0;
    sq      = '0;
    for (int l = 0; l < LANES; l++) begin
      xl      = signed'(in_data[l*DATA_W +: DATA_W]);
      sq      = xl * xl;
      sum_d   = sum_d + SW'(xl);
      sumsq_d = sumsq_d + QW'(unsigned'(sq));
    end
  end

  // Statistics, sqrt step and divide step
  always_comb begin
    mean_c  = mode_q ? '0 : DATA_W'(sum_q >>> LG);
    msq_c   = RW'(sumsq_q >> LG);
    mm_c    = mean_c * mean_c;
    var_c   = signed'({2'b00, msq_c}) - RW2'(mm_c);
    rad_c   = (var_c < 0) ? RW2'(EPS_RAW) : unsigned'(var_c) + RW2'(EPS_RAW);
    st_c    = {srem_q, rad_q[RW-1 -: 2]};
    trial_c = {root_q, 2'b01};
    s_c     = (root_q == '0) ? DATA_W'(1) : root_q;
    dr_c    = {drem_q, (cnt_q == '0)};
  end

  // Output beat datapath for beat ocnt_q
  always_comb begin
    out_data_d = '0;
    idx  = '0;
    xo   = '0;
    prod = '0;
    nn   = '0;
    yw   = '0;
    for (int l = 0; l < LANES; l++) begin
      idx  = eidx(ocnt_q, l);
      xo   = buf_q[idx];
      prod = (PW'(xo) - PW'(mean_q)) * PW'(signed'({1'b0, inv_q}));
      nn   = prod >>> RECIP_W;
      yw   = (YW'(nn) * YW'(gamma_q[idx])) >>> FRAC_W;
      yw   = yw + YW'(beta_q[idx]);
      out_data_d[l*DATA_W +: DATA_W] = sat_y(yw);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      bcnt_q      <= '0;
      ocnt_q      <= '0;
      sum_q       <= '0;
      sumsq_q     <= '0;
      mode_q      <= 1'b0;
      mean_q      <= '0;
      rad_q       <= '0;
      root_q      <= '0;
      srem_q      <= '0;
      drem_q      <= '0;
      inv_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < DIM; i++) begin
        buf_q[i]   <= '0;
        gamma_q[i] <= '0;
        beta_q[i]  <= '0;
      end
    end else begin
      // Address space is exactly 2*DIM, so the top address bit selects beta
      if (cfg_we && state_q == LOAD && bcnt_q == '0) begin
        if (cfg_addr[LG]) beta_q[cfg_addr[LG-1:0]]  <= signed'(cfg_wdata);
        else              gamma_q[cfg_addr[LG-1:0]] <= signed'(cfg_wdata);
      end
      case (state_q)
        LOAD: begin
          if (in_valid) begin
            for (int l = 0; l < LANES; l++)
              buf_q[eidx(bcnt_q, l)] <= signed'(in_data[l*DATA_W +: DATA_W]);
            sum_q   <= sum_d;
            sumsq_q <= sumsq_d;
            if (bcnt_q == '0) mode_q <= mode_rms;
            if (bcnt_q == BCW'(NB-1)) begin
              bcnt_q  <= '0;
              state_q <= STATS;
            end else begin
              bcnt_q <= bcnt_q + 1'b1;
            end
          end
        end
        STATS: begin
          mean_q  <= mean_c;
          rad_q   <= sat_rad(rad_c);
          root_q  <= '0;
          srem_q  <= '0;
          cnt_q   <= '0;
          state_q <= SQRT;
        end
        SQRT: begin
          if (st_c >= trial_c) begin
            srem_q <= DATA_W'(st_c - trial_c);
            root_q <= {root_q[DATA_W-2:0], 1'b1};
          end else begin
            srem_q <= DATA_W'(st_c);
            root_q <= {root_q[DATA_W-2:0], 1'b0};
          end
          rad_q <= rad_q << 2;
          if (cnt_q == CW'(DATA_W-1)) begin
            cnt_q   <= '0;
            drem_q  <= '0;
            inv_q   <= '0;
            state_q <= DIV;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DIV: begin
          if (dr_c >= {1'b0, s_c}) begin
            drem_q <= DATA_W'(dr_c - {1'b0, s_c});
            inv_q  <= {inv_q[QTW-2:0], 1'b1};
          end else begin
            drem_q <= dr_c[DATA_W-1:0];
            inv_q  <= {inv_q[QTW-2:0], 1'b0};
          end
          if (cnt_q == CW'(QTW-1)) begin
            cnt_q   <= '0;
            ocnt_q  <= '0;
            state_q <= OUT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        OUT: begin
          // Output registers reload only when empty or when the held beat is taken
          if (!out_valid_q || out_ready) begin
            if (out_valid_q && out_last_q) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              ocnt_q      <= '0;
              sum_q       <= '0;
              sumsq_q     <= '0;
              state_q     <= LOAD;
            end else begin
              out_data_q  <= out_data_d;
              out_valid_q <= 1'b1;
              out_last_q  <= (ocnt_q == BCW'(NB-1));
              ocnt_q      <= ocnt_q + 1'b1;
            end
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign in_ready  = (state_q == LOAD);
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
endmodule

// File: tb/tb_layernorm_stream.sv
// Directed bench for layernorm_stream: one DIM=8/LANES=1 instance for the main scenarios and
// one DIM=8/LANES=2 instance for output backpressure.
module tb_layernorm_stream;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, mode_rms, cfg_we;
  logic [3:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        in_valid, in_ready, out_valid, out_ready, out_last;
  logic [15:0] in_data, out_data;
  logic        in_valid2, in_ready2, out_valid2, out_ready2, out_last2;
  logic [31:0] in_data2, out_data2;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [15:0] vec [8];
  logic [15:0]        got [8];
  logic               gl  [8];
  int                 lat, t_acc;
  bit                 tmo;
  logic               post_rdy, post_vld;

  layernorm_stream #(.DIM(8), .LANES(1)) dut (
    .clk(clk), .rst_n(rst_n), .mode_rms(mode_rms),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata));

  layernorm_stream #(.DIM(8), .LANES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .mode_rms(mode_rms),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .out_last(out_last2),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata));

  task automatic cfg_wr(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic set_coef(input logic [15:0] g, input logic [15:0] bstep, input logic [15:0] b0);
    for (int i = 0; i < 8; i++) cfg_wr(4'(i), g);
    for (int i = 0; i < 8; i++) cfg_wr(4'(8 + i), 16'(b0 + bstep * 16'(i)));
  endtask

  // Sends vec[] to dut, optionally flips mode_rms after beat 0 and optionally attempts
  // beta writes while the divider runs; collects the 8 output beats.
  task automatic run_vec(input logic m, input bit flip, input bit inject);
    int k, guard, rel;
    @(negedge clk);
    mode_rms = m;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = vec[i];
      @(negedge clk);
      if (flip && i == 0) mode_rms = ~m;
    end
    in_valid = 1'b0;
    t_acc = cyc;
    k = 0; guard = 0; lat = -1;
    while (k < 8 && guard < 300) begin
      rel = cyc - t_acc;
      if (inject && rel >= 25 && rel <= 32) begin
        cfg_we = 1'b1; cfg_addr = 4'(8 + rel - 25); cfg_wdata = 16'h1234;
      end else begin
        cfg_we = 1'b0;
      end
      if (out_valid === 1'b1) begin
        if (lat < 0) lat = cyc - t_acc;
        got[k] = out_data;
        gl[k]  = out_last;
        k++;
      end
      @(negedge clk);
      guard++;
    end
    cfg_we   = 1'b0;
    tmo      = (k < 8);
    post_rdy = in_ready;
    post_vld = out_valid;
    mode_rms = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
    checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 0000", out_data); end
    checks++; if (in_ready2 !== 1'b1 || out_valid2 !== 1'b0 || out_data2 !== 32'h0) begin
      errors++; $display("FAIL reset_dut2: got rdy=%b vld=%b data=%h expected 1 0 0", in_ready2, out_valid2, out_data2);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_alternating();
    logic [15:0] e;
    set_coef(16'd256, 16'd0, 16'd0);
    for (int i = 0; i < 8; i++) vec[i] = (i % 2 == 0) ? 16'sd256 : -16'sd256;
    run_vec(1'b0, 1'b0, 1'b0);
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL alt_timeout: got %0d expected 0", tmo); end
    for (int i = 0; i < 8; i++) begin
      e = (i % 2 == 0) ? 16'd256 : 16'hFF00;
      checks++; if (got[i] !== e) begin errors++; $display("FAIL alt_data[%0d]: got %0d expected %0d", i, $signed(got[i]), $signed(e)); end
      checks++; if (gl[i] !== (i == 7)) begin errors++; $display("FAIL alt_last[%0d]: got %b expected %b", i, gl[i], (i == 7)); end
    end
    checks++; if (lat !== 43) begin errors++; $display("FAIL alt_latency: got %0d expected 43", lat); end
    checks++; if (post_rdy !== 1'b1) begin errors++; $display("FAIL alt_in_ready_after: got %b expected 1", post_rdy); end
    checks++; if (post_vld !== 1'b0) begin errors++; $display("FAIL alt_out_valid_after: got %b expected 0", post_vld); end
  endtask

  task automatic test_const_beta();
    set_coef(16'd256, 16'd16, 16'd0);
    for (int i = 0; i < 8; i++) vec[i] = 16'sd256;
    run_vec(1'b0, 1'b0, 1'b0);
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL beta_timeout: got %0d expected 0", tmo); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (got[i] !== 16'(i * 16)) begin errors++; $display("FAIL beta_data[%0d]: got %0d expected %0d", i, $signed(got[i]), i * 16); end
    end
  endtask

  task automatic test_rms();
    set_coef(16'd256, 16'd0, 16'd0);
    for (int i = 0; i < 8; i++) vec[i] = 16'sd256;
    run_vec(1'b1, 1'b1, 1'b0);
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL rms_timeout: got %0d expected 0", tmo); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (got[i] !== 16'd256) begin errors++; $display("FAIL rms_data[%0d]: got %0d expected 256", i, $signed(got[i])); end
    end
  endtask

  task automatic test_saturation();
    logic [15:0] e;
    set_coef(16'h7FFF, 16'd0, 16'h0100);
    for (int i = 0; i < 8; i++) vec[i] = (i % 2 == 0) ? 16'sd256 : -16'sd256;
    run_vec(1'b0, 1'b0, 1'b0);
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL sat_timeout: got %0d expected 0", tmo); end
    for (int i = 0; i < 8; i++) begin
      e = (i % 2 == 0) ? 16'h7FFF : 16'h8101;
      checks++; if (got[i] !== e) begin errors++; $display("FAIL sat_data[%0d]: got %0d expected %0d", i, $signed(got[i]), $signed(e)); end
    end
  endtask

  task automatic test_backpressure();
    logic signed [15:0] x2 [8];
    logic signed [15:0] y2 [8];
    logic [31:0] got2 [4];
    logic        gl2  [4];
    logic [31:0] sd, e;
    logic        sl, rdy, prev_stall;
    int          k, g, vc;
    x2 = '{16'sd256, -16'sd256, 16'sd512, -16'sd512, 16'sd0, 16'sd768, -16'sd768, 16'sd0};
    y2 = '{16'sd137, -16'sd138, 16'sd274, -16'sd275, 16'sd0, 16'sd411, -16'sd412, 16'sd0};
    set_coef(16'd256, 16'd0, 16'd0);
    out_ready2 = 1'b1;
    @(negedge clk);
    checks++; if (in_ready2 !== 1'b1) begin errors++; $display("FAIL bp_in_ready_idle: got %b expected 1", in_ready2); end
    for (int b = 0; b < 4; b++) begin
      in_valid2 = 1'b1;
      in_data2  = {x2[2*b+1], x2[2*b]};
      @(negedge clk);
    end
    in_valid2 = 1'b0;
    k = 0; g = 0; vc = 0; prev_stall = 1'b0; sd = '0; sl = 1'b0;
    while (k < 4 && g < 400) begin
      if (prev_stall) begin
        checks++; if (out_data2 !== sd || out_last2 !== sl) begin
          errors++; $display("FAIL bp_stable: got data=%h last=%b expected data=%h last=%b", out_data2, out_last2, sd, sl);
        end
      end
      checks++; if (in_ready2 !== 1'b0) begin errors++; $display("FAIL bp_in_ready_busy: got %b expected 0", in_ready2); end
      rdy = (vc < 6) ? vc[0] : 1'($urandom_range(0, 1));
      out_ready2 = rdy;
      if (out_valid2 === 1'b1 && rdy) begin
        got2[k] = out_data2;
        gl2[k]  = out_last2;
        k++;
      end
      prev_stall = (out_valid2 === 1'b1) && !rdy;
      sd = out_data2;
      sl = out_last2;
      if (out_valid2 === 1'b1) vc++;
      @(negedge clk);
      g++;
    end
    out_ready2 = 1'b1;
    checks++; if (k !== 4) begin errors++; $display("FAIL bp_beats: got %0d expected 4", k); end
    for (int b = 0; b < 4; b++) begin
      e = {y2[2*b+1], y2[2*b]};
      checks++; if (got2[b] !== e) begin errors++; $display("FAIL bp_data[%0d]: got %h expected %h", b, got2[b], e); end
      checks++; if (gl2[b] !== (b == 3)) begin errors++; $display("FAIL bp_last[%0d]: got %b expected %b", b, gl2[b], (b == 3)); end
    end
    checks++; if (in_ready2 !== 1'b1) begin errors++; $display("FAIL bp_in_ready_after: got %b expected 1", in_ready2); end
    checks++; if (out_valid2 !== 1'b0) begin errors++; $display("FAIL bp_out_valid_after: got %b expected 0", out_valid2); end
  endtask

  task automatic test_reset_abort();
    set_coef(16'd256, 16'd0, 16'd0);
    for (int i = 0; i < 8; i++) vec[i] = (i % 2 == 0) ? 16'sd256 : -16'sd256;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = vec[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", in_ready); end
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin errors++; $display("FAIL abort_out_flags: got vld=%b last=%b expected 0 0", out_valid, out_last); end
    checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL abort_out_data: got %h expected 0000", out_data); end
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(1'b0, 1'b0, 1'b1);
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL abort_timeout: got %0d expected 0", tmo); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (got[i] !== 16'h0) begin errors++; $display("FAIL abort_data[%0d]: got %0d expected 0", i, $signed(got[i])); end
    end
    checks++; if (lat !== 43) begin errors++; $display("FAIL abort_latency: got %0d expected 43", lat); end
    checks++; if (gl[7] !== 1'b1) begin errors++; $display("FAIL abort_last: got %b expected 1", gl[7]); end
  endtask

  initial begin
    rst_n = 1'b0; mode_rms = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b1;
    test_reset();
    test_alternating();
    test_const_beta();
    test_rms();
    test_saturation();
    test_backpressure();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/layernorm_stream.md
Name: layernorm_stream

Overview:
Synthesizable fixed-point successor to the combinational real-valued normaliser used ahead of attention and FFN blocks. It accepts a token vector of DIM elements as LANES-wide beats over a valid/ready stream and buffers it. It computes mean and variance (LayerNorm) or mean-square only (RMSNorm), then an inverse standard deviation through a bit-serial integer square root and a restoring divider. It streams out the affine-normalised vector with backpressure.

Parameters:
DIM, 64, elements per vector; power of two, at least LANES.
LANES, 1, elements per beat; power of two, divides DIM.
DATA_W, 16, signed element width for in/out/gamma/beta.
FRAC_W, 8, fractional bits of the Q(DATA_W,FRAC_W) format.
RECIP_W, 16, extra fractional bits of the inverse-std value.
EPS_RAW, 1, epsilon in raw squared-integer units, added to variance.

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
mode_rms  in  1  0=LayerNorm, 1=RMSNorm; sampled on the first accepted beat of each vector.
in_valid  in  1  input beat valid.
in_ready  out  1  block can accept a beat.
in_data  in  LANES*DATA_W  packed signed elements; lane 0 in LSBs; element index = beat*LANES+lane.
out_valid  out  1  output beat valid.
out_ready  in  1  downstream accepts beat.
out_data  out  LANES*DATA_W  packed results, same lane order.
out_last  out  1  final beat of vector.
cfg_we  in  1  gamma/beta write strobe.
cfg_addr  in  $clog2(2*DIM)  0..DIM-1 gamma[i], DIM..2DIM-1 beta[i-DIM].
cfg_wdata  in  DATA_W  signed coefficient.

Behaviour:
- Clocking and reset: one clock clk; reset rst_n is asynchronous, active-low. Reset drives state=LOAD, in_ready=1, out_valid=0, out_last=0, out_data=0, all counters/accumulators=0, gamma[]=0, beta[]=0, vector buffer=0.
- FSM states: LOAD, STATS, SQRT, DIV, OUT.
- LOAD: in_ready=1. Each in_valid&&in_ready beat stores LANES elements into buffer, adds them to sum (signed, DATA_W+log2 DIM bits) and squares to sumsq (unsigned, 2*DATA_W+log2 DIM bits). After beat DIM/LANES-1 goes to STATS. in_ready=0 in every other state.
- STATS (1 cycle):
  - mean = sum>>>log2(DIM) (floor), or 0 if mode_rms.
  - msq = sumsq>>log2(DIM).
  - var = msq - mean*mean, clamped at 0.
  - radicand = var+EPS_RAW, saturated to 2*DATA_W bits.
- SQRT (exactly DATA_W cycles): restoring integer sqrt, s = floor(sqrt(radicand)), s>=1.
- DIV (exactly FRAC_W+RECIP_W+1 cycles): restoring divide, inv = floor(2^(FRAC_W+RECIP_W)/s), unsigned FRAC_W+RECIP_W+1 bits.
- OUT: per element i:
  - n = ((x[i]-mean)*inv)>>>RECIP_W.
  - y = ((n*gamma[i])>>>FRAC_W) + beta[i].
  - Saturate y to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - All shifts are arithmetic (floor); intermediates wide enough that nothing wraps before saturation.
- OUT handshake: out_valid=1 while in OUT; beat k presents elements k*LANES..; out_data and out_last are stable while out_valid&&!out_ready. Beat advances on out_valid&&out_ready. out_last=1 only on beat DIM/LANES-1; its handshake returns to LOAD with sums cleared (in_ready=1 next cycle).
- Latency: first out_valid rises DATA_W+FRAC_W+RECIP_W+3 cycles after the clock edge accepting the last input beat (43 at defaults). No overlap between vectors; throughput is one vector per (load + compute + drain).
- cfg_we: honoured only in LOAD while no beat of the current vector has been accepted; otherwise ignored. Writes to cfg_addr >= 2*DIM are ignored.
- in_valid with in_ready=0 is ignored, with no state change. Reset asserted mid-vector aborts the vector and clears coefficients.
- mode_rms is held internally for the whole vector; changes mid-vector have no effect.

Test Plan:
- DIM=8, LANES=1, defaults; gamma=256, beta=0; input alternating +256,-256 in LayerNorm -> mean 0, var 65536, s=256, inv=65536; outputs alternate +256,-256; out_last on 8th beat; first out_valid 43 cycles after last input.
- All elements 256, beta[i]=i*16, gamma=256, LayerNorm -> var 0, s=1; every output = beta[i] (0,16,...,112).
- Same all-256 vector, RMSNorm, gamma=256, beta=0 -> msq 65536, s=256; all outputs 256.
- Saturation: alternating +/-256, gamma=0x7FFF, beta=0x0100 -> even outputs 0x7FFF (clamped from 33023), odd outputs -32511.
- Backpressure: LANES=2, out_ready toggling 1/0 every cycle and randomly -> out_data/out_last stable while stalled, all 4 beats delivered in order, in_ready=0 until last handshake, then 1 next cycle.
- Reset mid-SQRT and a cfg_we attempt during DIV -> after reset, outputs/state are reset values; the DIV-time write has no effect (readback via output with beta=0 gives 0).
